// File: rtl/pcm_sample_fifo_pkg.sv
// Shared audio definitions for the PCM sample path.
// Provides the PCM sample width and type, and the width of the overflow drop counter.
package pcm_sample_fifo_pkg;

  localparam int PCM_WIDTH      = 16;
  localparam int DROP_CNT_WIDTH = 16;

  typedef logic signed [PCM_WIDTH-1:0] pcm_sample_t;

endpackage

// File: rtl/pcm_sample_fifo_if.sv
// Valid/ready sample stream between the PCM FIFO and its consumer.
//   m_data  : head-of-queue sample (producer -> consumer)
//   m_valid : m_data holds a valid sample (producer -> consumer)
//   m_ready : consumer accepts; a transfer occurs when m_valid && m_ready
// The master modport is the producer (FIFO) side; the slave modport is the consumer side.
interface pcm_sample_fifo_if
  import pcm_sample_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = PCM_WIDTH
);

  logic signed [DATA_WIDTH-1:0] m_data;
  logic                         m_valid;
  logic                         m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/pcm_sample_fifo_sync_ram_1r1w.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Kept as its own module so the storage can later be swapped for a BRAM/LUTRAM wrapper.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// Contents are not reset.
module sync_ram_1r1w #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pcm_sample_fifo.sv
// Downstream buffer for the decimated PCM stream.
// Captures every pcm_valid strobe without backpressure and presents samples first-word-
// fall-through on a valid/ready stream. Reports fill level and almost-full; when full,
// incoming samples are dropped, a sticky overflow flag is set and a saturating drop
// counter advances.
//   clk, rst    : clock, synchronous active-high reset
//   pcm_in      : signed sample from the decimator
//   pcm_valid   : one-cycle strobe; sample is stored or dropped the same cycle
//   m_if        : output stream (m_data, m_valid, m_ready)
//   level       : number of stored samples, 0..DEPTH
//   almost_full : level >= AFULL_LEVEL
//   overflow    : sticky, at least one sample dropped since reset/clear
//   drop_count  : dropped samples, saturating
//   ovf_clear   : clears overflow and drop_count (a coincident drop wins)
module pcm_sample_fifo
  import pcm_sample_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = PCM_WIDTH,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  pcm_in,
  input  logic                          pcm_valid,
  pcm_sample_fifo_if.master             m_if,
  output logic [LW-1:0]                 level,
  output logic                          almost_full,
  output logic                          overflow,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count,
  input  logic                          ovf_clear
);

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  m_valid_q;
  logic [LW-1:0]         level_nxt;
  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  drop;
  logic [DATA_WIDTH-1:0] rd_data;

  assign full  = (level == LW'(DEPTH));
  assign pop   = m_valid_q && m_if.m_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = pcm_valid && (!full || pop);
  assign drop  = pcm_valid && full && !pop;

  always_comb begin
    level_nxt = level;
    if (wr_en && !pop) begin
      level_nxt = level + 1'b1;
    end else if (!wr_en && pop) begin
      level_nxt = level - 1'b1;
    end
  end

  sync_ram_1r1w #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en && !rst),
    .waddr (wr_ptr),
    .wdata (pcm_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointers, level and flags: all registered from level_nxt so they agree after every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      m_valid_q   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level       <= level_nxt;
      m_valid_q   <= (level_nxt != '0);
      almost_full <= (level_nxt >= LW'(AFULL_LEVEL));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= ovf_clear ? DROP_CNT_WIDTH'(1) : sat_inc(drop_count);
    end else if (ovf_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Memory is not reset, so the head is masked to zero while empty.
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_data  = m_valid_q ? $signed(rd_data) : '0;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
module tb_pcm_sample_fifo;
  import pcm_sample_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic              clk;
  logic              rst;
  pcm_sample_t       pcm_in;
  logic              pcm_valid;
  logic              ovf_clear;
  logic [4:0]        level;
  logic              almost_full;
  logic              overflow;
  logic [15:0]       drop_count;

  pcm_sample_fifo_if #(.DATA_WIDTH(PCM_WIDTH)) s_if ();

  pcm_sample_fifo #(
    .DATA_WIDTH  (PCM_WIDTH),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pcm_in      (pcm_in),
    .pcm_valid   (pcm_valid),
    .m_if        (s_if),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .ovf_clear   (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard model
  logic [15:0] exp_q[$];
  logic        mdl_ovf;
  logic [15:0] mdl_drops;
  logic [15:0] last_pop;
  int          mon_sz;
  logic        mon_pop;
  logic [15:0] mon_exp;

  initial begin
    mdl_ovf   = 1'b0;
    mdl_drops = '0;
    last_pop  = '0;
  end

  // Inputs change 1 time unit after posedge; at negedge they describe the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl_ovf   = 1'b0;
      mdl_drops = '0;
    end else begin
      mon_sz  = exp_q.size();
      mon_pop = (mon_sz != 0) && s_if.m_ready;
      if (mon_pop) begin
        mon_exp = exp_q.pop_front();
        last_pop = mon_exp;
        checks++;
        if (s_if.m_valid !== 1'b1 || s_if.m_data !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got valid=%b data=%h, expected valid=1 data=%h",
                   s_if.m_valid, s_if.m_data, mon_exp);
        end
      end else if (s_if.m_ready && s_if.m_valid) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got data=%h with model empty", s_if.m_data);
      end
      if (pcm_valid && (mon_sz < DEPTH || mon_pop)) begin
        exp_q.push_back(pcm_in);
      end else if (pcm_valid) begin
        mdl_ovf   = 1'b1;
        mdl_drops = ovf_clear ? 16'd1 : ((mdl_drops == 16'hFFFF) ? mdl_drops : mdl_drops + 16'd1);
      end else if (ovf_clear) begin
        mdl_ovf   = 1'b0;
        mdl_drops = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    pcm_in    = v;
    pcm_valid = 1'b1;
    step();
    pcm_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    s_if.m_ready = 1'b1;
    repeat (n) step();
    s_if.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d, expected 0", level); end
    checks++;
    if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b, expected 0", s_if.m_valid); end
    checks++;
    if (s_if.m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data: got %h, expected 0000", s_if.m_data); end
    checks++;
    if (almost_full !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_flags: got af=%b ovf=%b drops=%0d, expected 0 0 0", almost_full, overflow, drop_count);
    end
  endtask

  task automatic test_basic_order();
    push(16'h7FFF);
    push(16'h8000);
    push(16'h0001);
    checks++;
    if (level !== 5'd3 || s_if.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_level: got level=%0d valid=%b, expected 3 1", level, s_if.m_valid);
    end
    repeat (3) step();
    checks++;
    if (s_if.m_data !== 16'h7FFF) begin errors++; $display("FAIL basic_hold: got %h, expected 7fff", s_if.m_data); end
    drain(3);
    checks++;
    if (level !== 5'd0 || s_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: got level=%0d valid=%b, expected 0 0", level, s_if.m_valid);
    end
    checks++;
    if (last_pop !== 16'h0001 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_last: got last=%h left=%0d, expected 0001 0", last_pop, exp_q.size());
    end
  endtask

  task automatic test_latency();
    pcm_in    = 16'sh1234;
    pcm_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got valid=%b, expected 0", s_if.m_valid); end
    step();
    pcm_valid = 1'b0;
    checks++;
    if (s_if.m_valid !== 1'b1 || s_if.m_data !== 16'h1234) begin
      errors++;
      $display("FAIL latency_edge: got valid=%b data=%h, expected 1 1234", s_if.m_valid, s_if.m_data);
    end
    drain(2);
  endtask

  task automatic test_almost_full();
    for (int i = 0; i < 11; i++) push(16'h0A00 + 16'(i));
    checks++;
    if (almost_full !== 1'b0 || level !== 5'd11) begin
      errors++;
      $display("FAIL af_below: got af=%b level=%0d, expected 0 11", almost_full, level);
    end
    push(16'h0A0B);
    checks++;
    if (almost_full !== 1'b1 || level !== 5'd12) begin
      errors++;
      $display("FAIL af_rise: got af=%b level=%0d, expected 1 12", almost_full, level);
    end
    drain(1);
    checks++;
    if (almost_full !== 1'b0 || level !== 5'd11) begin
      errors++;
      $display("FAIL af_fall: got af=%b level=%0d, expected 0 11", almost_full, level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) push(16'hB000 + 16'(i));
    checks++;
    if (level !== 5'd16) begin errors++; $display("FAIL ovf_full: got level=%0d, expected 16", level); end
    for (int i = 0; i < 3; i++) push(16'hDEAD + 16'(i));
    checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 16'd3) begin
      errors++;
      $display("FAIL ovf_drop: got level=%0d ovf=%b drops=%0d, expected 16 1 3", level, overflow, drop_count);
    end
    checks++;
    if (drop_count !== mdl_drops || overflow !== mdl_ovf) begin
      errors++;
      $display("FAIL ovf_model: got drops=%0d ovf=%b, expected %0d %b", drop_count, overflow, mdl_drops, mdl_ovf);
    end
    drain(18);
    checks++;
    if (level !== 5'd0 || last_pop !== 16'hB004) begin
      errors++;
      $display("FAIL ovf_drain: got level=%0d last=%h, expected 0 b004", level, last_pop);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(16'h1000 + 16'(i));
    pcm_in       = 16'hABCD;
    pcm_valid    = 1'b1;
    s_if.m_ready = 1'b1;
    step();
    pcm_valid    = 1'b0;
    s_if.m_ready = 1'b0;
    checks++;
    if (level !== 5'd16 || drop_count !== 16'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fullpp_state: got level=%0d drops=%0d ovf=%b, expected 16 3 1", level, drop_count, overflow);
    end
    drain(18);
    checks++;
    if (last_pop !== 16'hABCD || level !== 5'd0) begin
      errors++;
      $display("FAIL fullpp_last: got last=%h level=%0d, expected abcd 0", last_pop, level);
    end
  endtask

  task automatic test_ovf_clear();
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_plain: got ovf=%b drops=%0d, expected 0 0", overflow, drop_count);
    end
    for (int i = 0; i < 17; i++) push(16'h2000 + 16'(i));
    checks++;
    if (drop_count !== 16'd1) begin errors++; $display("FAIL clr_predrop: got drops=%0d, expected 1", drop_count); end
    push(16'h2100);
    push(16'h2101);
    pcm_in    = 16'h2200;
    pcm_valid = 1'b1;
    ovf_clear = 1'b1;
    step();
    pcm_valid = 1'b0;
    ovf_clear = 1'b0;
    checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd1 || level !== 5'd16) begin
      errors++;
      $display("FAIL clr_drop_wins: got ovf=%b drops=%0d level=%0d, expected 1 1 16", overflow, drop_count, level);
    end
    drain(18);
    checks++;
    if (last_pop !== 16'h200F || level !== 5'd0) begin
      errors++;
      $display("FAIL clr_data: got last=%h level=%0d, expected 200f 0", last_pop, level);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) push(16'h3000 + 16'(i));
    checks++;
    if (level !== 5'd5) begin errors++; $display("FAIL rstmid_pre: got level=%0d, expected 5", level); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (level !== 5'd0 || s_if.m_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_post: got level=%0d valid=%b ovf=%b drops=%0d, expected 0 0 0 0",
               level, s_if.m_valid, overflow, drop_count);
    end
    push(16'h5A5A);
    checks++;
    if (s_if.m_data !== 16'h5A5A || level !== 5'd1) begin
      errors++;
      $display("FAIL rstmid_after: got data=%h level=%0d, expected 5a5a 1", s_if.m_data, level);
    end
    drain(2);
    checks++;
    if (exp_q.size() != 0 || s_if.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drain: got left=%0d valid=%b, expected 0 0", exp_q.size(), s_if.m_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    pcm_in       = '0;
    pcm_valid    = 1'b0;
    ovf_clear    = 1'b0;
    s_if.m_ready = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_basic_order();
    test_latency();
    test_almost_full();
    test_overflow();
    test_full_push_pop();
    test_ovf_clear();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcm_sample_fifo.md
Name: pcm_sample_fifo

Overview:
Downstream buffer for the decimated PCM stream from the CIC/HPF stage. It captures every pcm_valid pulse without backpressure and presents the samples on a valid/ready stream for the consumer (serializer, DMA or test readout). It reports fill level and almost-full. On overflow it drops samples, records a sticky flag and keeps a saturating drop count.

Parameters:
DATA_WIDTH, 16, PCM sample width (matches decimator pcm_out)
DEPTH, 16, storage entries; power of two, >= 4
AFULL_LEVEL, 12, almost_full asserted when level >= AFULL_LEVEL

Ports:
clk  in  1  single clock, same domain as the decimator
rst  in  1  synchronous, active-high reset
pcm_in  in  DATA_WIDTH  signed sample from decimator
pcm_valid  in  1  one-cycle strobe; sample must be taken or dropped this cycle (no stall possible)
m_data  out  DATA_WIDTH  head-of-queue sample
m_valid  out  1  m_data holds a valid sample
m_ready  in  1  consumer accepts; a pop occurs when m_valid && m_ready
level  out  $clog2(DEPTH)+1  number of stored samples, 0..DEPTH
almost_full  out  1  level >= AFULL_LEVEL
overflow  out  1  sticky: at least one sample dropped since reset/clear
drop_count  out  16  dropped samples, saturates at 16'hFFFF
ovf_clear  in  1  clears overflow and drop_count

Behaviour:
- Reset (rst=1 at clk edge): pointers=0, level=0, m_valid=0, m_data=0, almost_full=0, overflow=0, drop_count=0. Memory contents are don't-care. Reset mid-stream discards all stored samples; no pop is reported that cycle.
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0. Fill level is held in an explicit counter (not pointer difference).
- Write: pcm_valid && (level < DEPTH || pop) -> store at wr_ptr, wr_ptr++. When full, a write accompanied by a pop in the same cycle is accepted.
- Drop: pcm_valid && level == DEPTH && !pop -> sample discarded, overflow <= 1, drop_count++ (saturating).
- Pop: m_valid && m_ready -> rd_ptr++.
- Level update: +1 on write only, -1 on pop only, unchanged on both or neither.
- Output is first-word-fall-through with registered flags. m_valid = (level != 0). m_data = mem[rd_ptr], updated by the clock edge.
  - Latency: a sample written at edge N into an empty FIFO shows m_valid=1 and m_data=sample after edge N.
  - No same-cycle input-to-output bypass.
- m_data holds stable while m_valid && !m_ready.
- almost_full and level are registered and consistent with each other after every edge.
- ovf_clear at the same edge as a drop: the drop wins. overflow=1, drop_count=1.
- ovf_clear has no effect on stored data or pointers.
- Input sign is irrelevant to the FIFO; samples pass bit-exact.
- pcm_valid arrives at most once per 64 clk from the decimator. The block must nevertheless handle back-to-back pcm_valid every cycle.

Decomposition:
- Shared audio package: PCM_WIDTH=16, the signed PCM sample typedef, DROP_CNT_WIDTH=16.
- One sub-module: sync_ram_1r1w (DEPTH x DATA_WIDTH, synchronous write, asynchronous read), so the storage can later map to a BRAM/LUTRAM wrapper.
- Pointer, level and flag logic stay in pcm_sample_fifo.

Test Plan:
- Reset, then push 16'sh7FFF, 16'sh8000, 16'sh0001 with m_ready=0 -> level=3, m_valid=1, m_data=7FFF held. Raise m_ready -> pops in order 7FFF, 8000, 0001, then m_valid=0, level=0.
- Single write into empty FIFO at edge N -> m_valid rises exactly after edge N with correct data, not earlier.
- Push 12 samples with m_ready=0 -> almost_full rises on the 12th write (level=12); pop one -> almost_full falls.
- Fill to 16, then 3 more pcm_valid with m_ready=0 -> level=16, overflow=1, drop_count=3. Drain -> first 16 samples intact, none of the dropped ones.
- Full FIFO, pcm_valid and m_ready in the same cycle -> write accepted, level stays 16, drop_count unchanged, new sample emerges last.
- Pulse ovf_clear -> overflow=0, drop_count=0. Pulse ovf_clear coincident with a drop -> overflow=1, drop_count=1. Pulse rst with 5 stored -> level=0, m_valid=0 next cycle.
